prog_loader: RTL

- Write-side companion to the instruction ROM.
- Accepts a byte stream over a valid/ready handshake and assembles Isize-bit instructions, most significant byte first.
- Writes assembled words sequentially into the writable program memory through a single write port, starting at address 0.
- busy holds the picoMIPS core in reset while a load is in progress.

---
 rtl/prog_loader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Write-side loader for the program memory: assembles MSB-first byte streams into words.
// Optional trailing checksum byte when PROG_LOADER_CKSUM_EN is defined.
module prog_loader #(
  parameter int unsigned Psize = 4,
  parameter int unsigned Isize = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [Psize:0]   len,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             we,
  output logic [Psize-1:0] waddr,
  output logic [Isize-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned NB  = (Isize + 7) / 8;
  localparam int unsigned PAD = 8 * NB - Isize;
  localparam int unsigned CW  = Psize + 1;
  localparam int unsigned SW  = 8 * (NB - 1);
  localparam int unsigned BW  = (NB > 2) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef PROG_LOADER_CKSUM_EN
    S_CKSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [Psize-1:0] addr, addr_d;
  logic [BW-1:0]    bcnt, bcnt_d;
  logic [SW-1:0]    shreg, shreg_d;
  logic [Isize-1:0] wdata_d;
  logic [Psize-1:0] waddr_d;
  logic             xfer, pad_bad, last_word;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]       sum, sum_d;
`endif

  assign xfer      = in_valid & in_ready;
  // Pad bits are the top PAD bits of the first byte of every word.
  assign pad_bad   = |(in_data >> (8 - PAD));
  assign last_word = ({1'b0, addr} == CW'(cnt - 1'b1));

  // Next-state and datapath update.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = addr;
    bcnt_d  = bcnt;
    shreg_d = shreg;
    wdata_d = wdata;
    waddr_d = waddr;
`ifdef PROG_LOADER_CKSUM_EN
    sum_d   = sum;
`endif
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          cnt_d   = (len == '0) ? CW'(1 << Psize) : len;
          addr_d  = '0;
          bcnt_d  = '0;
`ifdef PROG_LOADER_CKSUM_EN
          sum_d   = '0;
`endif
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (xfer) begin
          shreg_d = {shreg[SW-9:0], in_data};
`ifdef PROG_LOADER_CKSUM_EN
          sum_d   = 8'(sum + in_data);
`endif
          if (bcnt == '0 && pad_bad) begin
            state_d = S_ERR;
          end else if (bcnt == BW'(NB - 1)) begin
            bcnt_d  = '0;
            wdata_d = Isize'({shreg, in_data});
            waddr_d = addr;
            state_d = S_WRITE;
          end else begin
            bcnt_d  = BW'(bcnt + 1'b1);
          end
        end
      end
      S_WRITE: begin
        if (last_word) begin
`ifdef PROG_LOADER_CKSUM_EN
          state_d = S_CKSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          addr_d  = Psize'(addr + 1'b1);
          state_d = S_RECV;
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      S_CKSUM: begin
        if (xfer) begin
          state_d = (8'(sum + in_data) == 8'd0) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr     <= '0;
      bcnt     <= '0;
      shreg    <= '0;
      wdata    <= '0;
      waddr    <= '0;
      in_ready <= 1'b0;
      we       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
      sum      <= '0;
`endif
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      addr     <= addr_d;
      bcnt     <= bcnt_d;
      shreg    <= shreg_d;
      wdata    <= wdata_d;
      waddr    <= waddr_d;
      we       <= (state_d == S_WRITE);
      done     <= (state_d == S_DONE);
      err      <= (state_d == S_ERR);
`ifdef PROG_LOADER_CKSUM_EN
      sum      <= sum_d;
      in_ready <= (state_d == S_RECV) || (state_d == S_CKSUM);
      busy     <= (state_d == S_RECV) || (state_d == S_WRITE) || (state_d == S_CKSUM);
`else
      in_ready <= (state_d == S_RECV);
      busy     <= (state_d == S_RECV) || (state_d == S_WRITE);
`endif
    end
  end

endmodule
